// File: rtl/fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// fifo_stream_reader
//
// Read-side consumer stage for the dual-clock FIFO. Runs entirely in the FIFO
// read clock domain. It turns the FIFO pull interface (ReadEn/Empty, data
// registered one cycle after an accepted read) into a valid/ready stream. A
// 2-entry skid buffer is prefetched so the stream sustains one word per cycle.
// Every FRAME_LEN words the final word of the frame is flagged with Last_out.
//
// Handshake: a word transfers on a cycle where Valid_out & Ready_in. Once
// Valid_out is high, it stays high and Data_out stays stable until that
// transfer happens. Ready_in may depend on nothing from this block.
//
// Ports:
//   Clk              read-domain clock (same net as FIFO RClk)
//   Clear_in         synchronous active-high reset (same net as FIFO Clear_in)
//   Fifo_data_in     FIFO Data_out, valid the cycle after an accepted read
//   Fifo_empty_in    FIFO Empty_out
//   Fifo_rd_en_out   FIFO ReadEn_in; a read is accepted whenever this is 1
//   Data_out         stream data (skid buffer head)
//   Valid_out        stream valid
//   Ready_in         downstream ready
//   Last_out         Data_out is the final word of a frame
//   Word_idx_out     index of Data_out within its frame, 0..FRAME_LEN-1
//
// Optional feature (macro FIFO_STREAM_READER_STATS_EN):
//   Underrun_cnt_out 16-bit saturating count of cycles Ready_in & ~Valid_out
//   Stall_cnt_out    16-bit saturating count of cycles Valid_out & ~Ready_in
// -----------------------------------------------------------------------------
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int FRAME_LEN  = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  Clk,
    input  logic                  Clear_in,
    input  logic [DATA_WIDTH-1:0] Fifo_data_in,
    input  logic                  Fifo_empty_in,
    output logic                  Fifo_rd_en_out,
    output logic [DATA_WIDTH-1:0] Data_out,
    output logic                  Valid_out,
    input  logic                  Ready_in,
    output logic                  Last_out,
`ifdef FIFO_STREAM_READER_STATS_EN
    output logic [15:0]           Underrun_cnt_out,
    output logic [15:0]           Stall_cnt_out,
`endif
    output logic [CNT_WIDTH-1:0]  Word_idx_out
);

    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(FRAME_LEN - 1);

    // Skid buffer: entry 0 is the head, entry 1 the second word.
    logic [DATA_WIDTH-1:0] skid_q [2];
    logic [DATA_WIDTH-1:0] skid_d [2];
    logic [1:0]            occ_q, occ_d;     // words held, 0..2
    logic                  pend_q;           // read data arrives this cycle
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;     // position in current frame

    logic       valid;
    logic       pop;
    logic       push;
    logic       rd_en;
    logic [1:0] tail;

    assign valid = ~Clear_in & (occ_q != 2'd0);
    assign pop   = valid & Ready_in;
    assign push  = pend_q;

    // Issue a read only if the word it returns is guaranteed a slot:
    // occ + pend - pop < 2, rearranged to avoid an unsigned underflow.
    assign rd_en = ~Clear_in & ~Fifo_empty_in &
                   (({1'b0, occ_q} + {2'b00, pend_q}) < (3'd2 + {2'b00, pop}));

    // Slot the incoming word lands in after this cycle's pop has shifted.
    assign tail = occ_q - {1'b0, pop};

    always_comb begin
        skid_d[0] = skid_q[0];
        skid_d[1] = skid_q[1];
        occ_d     = occ_q + {1'b0, push} - {1'b0, pop};
        cnt_d     = cnt_q;
        if (pop) begin
            skid_d[0] = skid_q[1];
            cnt_d     = (cnt_q == LAST_IDX) ? '0 : cnt_q + 1'b1;
        end
        if (push) begin
            if (tail == 2'd0) skid_d[0] = Fifo_data_in;
            else              skid_d[1] = Fifo_data_in;
        end
    end

    always_ff @(posedge Clk) begin
        if (Clear_in) begin
            skid_q[0] <= '0;
            skid_q[1] <= '0;
            occ_q     <= 2'd0;
            pend_q    <= 1'b0;   // an in-flight word is simply never captured
            cnt_q     <= '0;
        end else begin
            skid_q[0] <= skid_d[0];
            skid_q[1] <= skid_d[1];
            occ_q     <= occ_d;
            pend_q    <= rd_en;
            cnt_q     <= cnt_d;
        end
    end

    assign Fifo_rd_en_out = rd_en;
    assign Valid_out      = valid;
    assign Data_out       = Clear_in ? '0 : skid_q[0];
    assign Word_idx_out   = Clear_in ? '0 : cnt_q;
    assign Last_out       = valid & (cnt_q == LAST_IDX);

`ifdef FIFO_STREAM_READER_STATS_EN
    logic [15:0] underrun_q;
    logic [15:0] stall_q;

    always_ff @(posedge Clk) begin
        if (Clear_in) begin
            underrun_q <= 16'd0;
            stall_q    <= 16'd0;
        end else begin
            if (Ready_in & ~valid & (underrun_q != 16'hFFFF))
                underrun_q <= underrun_q + 16'd1;
            if (valid & ~Ready_in & (stall_q != 16'hFFFF))
                stall_q <= stall_q + 16'd1;
        end
    end

    assign Underrun_cnt_out = underrun_q;
    assign Stall_cnt_out    = stall_q;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader. A FIFO model feeds the DUT with registered
// read data; a scoreboard queue holds every word pushed into the FIFO in
// order, and the frame index is tracked as a plain pop count modulo FL.
module tb_fifo_stream_reader;

  localparam int DW = 8;
  localparam int FL = 4;
  localparam int CW = 16;

  logic          Clk = 1'b0;
  logic          Clear_in = 1'b1;
  logic [DW-1:0] Fifo_data_in = '0;
  logic          Fifo_empty_in;
  logic          Fifo_rd_en_out;
  logic [DW-1:0] Data_out;
  logic          Valid_out;
  logic          Ready_in = 1'b0;
  logic          Last_out;
  logic [CW-1:0] Word_idx_out;
`ifdef FIFO_STREAM_READER_STATS_EN
  logic [15:0]   Underrun_cnt_out;
  logic [15:0]   Stall_cnt_out;
`endif

  fifo_stream_reader #(.DATA_WIDTH(DW), .FRAME_LEN(FL), .CNT_WIDTH(CW)) dut (
    .Clk            (Clk),
    .Clear_in       (Clear_in),
    .Fifo_data_in   (Fifo_data_in),
    .Fifo_empty_in  (Fifo_empty_in),
    .Fifo_rd_en_out (Fifo_rd_en_out),
    .Data_out       (Data_out),
    .Valid_out      (Valid_out),
    .Ready_in       (Ready_in),
    .Last_out       (Last_out),
`ifdef FIFO_STREAM_READER_STATS_EN
    .Underrun_cnt_out (Underrun_cnt_out),
    .Stall_cnt_out    (Stall_cnt_out),
`endif
    .Word_idx_out   (Word_idx_out)
  );

  // clock / reset
  always #5 Clk = ~Clk;

  // FIFO model: write side owned by the initial block, read side by this block
  logic [DW-1:0] fifo_mem [256];
  logic [7:0]    wr_ptr = 8'd0;
  logic [7:0]    rd_ptr = 8'd0;
  assign Fifo_empty_in = (wr_ptr == rd_ptr);

  always @(posedge Clk) begin
    if (Fifo_rd_en_out) begin
      Fifo_data_in <= fifo_mem[rd_ptr];
      rd_ptr       <= rd_ptr + 8'd1;
    end
  end

  // scoreboard
  logic [DW-1:0] exp_q[$];
  int            exp_idx = 0;
  int            vectors = 0;
  int            miscompares = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          obs_valid;
  logic          obs_rd;
  int            rd_count = 0;
  int            last_pops = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fifo_push(input logic [DW-1:0] w);
    fifo_mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 8'd1;
    exp_q.push_back(w);
  endtask

  // driver: one clock cycle with the given inputs, checked against the model
  task automatic step(input logic rdy, input logic clr);
    logic pop;
    Ready_in = rdy;
    Clear_in = clr;
    #1;
    obs_valid = Valid_out;
    obs_rd    = Fifo_rd_en_out;
    if (obs_rd) rd_count++;
    if (clr) begin
      chk("rst_valid", Valid_out, 0);
      chk("rst_rd_en", Fifo_rd_en_out, 0);
      chk("rst_last", Last_out, 0);
      chk("rst_data", Data_out, 0);
      chk("rst_idx", Word_idx_out, 0);
      exp_q.delete();
      exp_idx    = 0;
      prev_stall = 1'b0;
    end else begin
      chk("rd_when_empty", Fifo_rd_en_out & Fifo_empty_in, 0);
      chk("occ_le_2", dut.occ_q <= 2'd2, 1);
      if (prev_stall) begin
        chk("stall_valid", Valid_out, 1);
        chk("stall_data", Data_out, prev_data);
      end
      if (Valid_out) begin
        chk("word_idx", Word_idx_out, exp_idx);
        chk("last", Last_out, exp_idx == FL - 1);
      end
      pop = Valid_out & rdy;
      if (pop) begin
        chk("word_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("data", Data_out, exp_q.pop_front());
        if (Last_out) last_pops++;
        exp_idx = (exp_idx + 1) % FL;
      end
      prev_stall = Valid_out & ~rdy;
      prev_data  = Data_out;
    end
    @(posedge Clk);
    @(negedge Clk);
  endtask

  initial begin
    @(negedge Clk);
    repeat (3) step(1'b0, 1'b1);

    // latency and back-to-back output with a preloaded FIFO
    for (int i = 1; i <= 5; i++) fifo_push(DW'(i));
    rd_count = 0;
    step(1'b1, 1'b0);
    chk("t1_rd_first", obs_rd, 1);
    chk("t1_valid_c0", obs_valid, 0);
    step(1'b1, 1'b0);
    chk("t1_valid_c1", obs_valid, 0);
    for (int c = 2; c <= 6; c++) begin
      step(1'b1, 1'b0);
      chk("t1_valid_run", obs_valid, 1);
    end
    step(1'b1, 1'b0);
    chk("t1_valid_end", obs_valid, 0);
    chk("t1_reads", rd_count, 5);
    chk("t1_drained", exp_q.size(), 0);

    // backpressure: only two reads while the consumer is stalled
    for (int i = 0; i < 10; i++) fifo_push(DW'($urandom_range(0, 255)));
    rd_count = 0;
    repeat (6) step(1'b0, 1'b0);
    chk("t2_reads", rd_count, 2);
    chk("t2_rd_stopped", obs_rd, 0);
    chk("t2_head_valid", Valid_out, 1);
    chk("t2_head_data", Data_out, exp_q[0]);
    repeat (16) step(1'b1, 1'b0);
    chk("t2_drained", exp_q.size(), 0);

    // ready toggling every cycle
    for (int i = 0; i < 32; i++) fifo_push(DW'($urandom_range(0, 255)));
    for (int c = 0; c < 80; c++) step(c[0] == 1'b0, 1'b0);
    chk("t3_drained", exp_q.size(), 0);

    // frame marking from index 0
    step(1'b0, 1'b1);
    for (int i = 0; i < 9; i++) fifo_push(DW'($urandom_range(0, 255)));
    last_pops = 0;
    repeat (14) step(1'b1, 1'b0);
    chk("t4_drained", exp_q.size(), 0);
    chk("t4_last_count", last_pops, 2);
    chk("t4_idx_after", exp_idx, 1);

    // clear while a read is in flight
    fifo_push(8'h55);
    step(1'b0, 1'b0);
    chk("t5_rd_issued", obs_rd, 1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    chk("t5_valid_after_clear", obs_valid, 0);
    fifo_push(8'hAA);
    repeat (5) step(1'b1, 1'b0);
    chk("t5_drained", exp_q.size(), 0);

    // random ready pattern
    for (int i = 0; i < 40; i++) fifo_push(DW'($urandom_range(0, 255)));
    repeat (150) step(1'($urandom_range(0, 1)), 1'b0);
    repeat (45) step(1'b1, 1'b0);
    chk("t6_drained", exp_q.size(), 0);

`ifdef FIFO_STREAM_READER_STATS_EN
    step(1'b0, 1'b1);
    chk("st_underrun_rst", Underrun_cnt_out, 0);
    chk("st_stall_rst", Stall_cnt_out, 0);
    repeat (5) step(1'b1, 1'b0);
    chk("st_underrun_5", Underrun_cnt_out, 5);
    fifo_push(8'h3C);
    repeat (5) step(1'b0, 1'b0);
    chk("st_stall_3", Stall_cnt_out, 3);
    chk("st_underrun_hold", Underrun_cnt_out, 5);
    step(1'b1, 1'b0);
    Ready_in = 1'b1;
    repeat (65540) @(posedge Clk);
    @(negedge Clk);
    #1;
    chk("st_underrun_sat", Underrun_cnt_out, 16'hFFFF);
    chk("st_stall_keep", Stall_cnt_out, 3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
Read-side consumer stage for the dual-clock FIFO. It runs entirely in the FIFO read clock domain.
- Converts the FIFO's pull interface into a valid/ready stream: ReadEn/Empty request, with registered data one cycle after the accepted read.
- Prefetches into a 2-entry skid buffer so the stream sustains one word per cycle.
- Marks frame boundaries with a last flag every FRAME_LEN words.

Parameters:
DATA_WIDTH, 8, width of the FIFO word and of the stream data.
FRAME_LEN, 16, words per frame; Last_out marks word FRAME_LEN-1 of each frame; legal range 1..65535.
CNT_WIDTH, 16, width of the frame word counter and of Word_idx_out.

Ports:
Clk  in  1  read-domain clock; same net as the FIFO RClk.
Clear_in  in  1  synchronous, active-high reset; drive with the same net as the FIFO Clear_in.
Fifo_data_in  in  DATA_WIDTH  FIFO Data_out; valid in the cycle after an accepted read.
Fifo_empty_in  in  1  FIFO Empty_out.
Fifo_rd_en_out  out  1  FIFO ReadEn_in.
Data_out  out  DATA_WIDTH  stream data; head of the skid buffer.
Valid_out  out  1  stream valid.
Ready_in  in  1  downstream ready.
Last_out  out  1  qualifies Data_out as the final word of a frame.
Word_idx_out  out  CNT_WIDTH  index of Data_out within its frame, 0..FRAME_LEN-1.

Behaviour:
- Single clock Clk. Reset is synchronous, active-high, on Clear_in. While Clear_in is high:
  - Fifo_rd_en_out = 0, Valid_out = 0, Last_out = 0, Word_idx_out = 0, Data_out = 0.
  - Skid occupancy = 0, pending flag = 0, frame counter = 0.
- Internal state:
  - occ (0..2): words held in the skid buffer.
  - pend (1 bit): an accepted read whose data arrives on Fifo_data_in this cycle.
- pop = Valid_out & Ready_in.
- Read issue (combinational): Fifo_rd_en_out = ~Clear_in & ~Fifo_empty_in & ((occ + pend - pop) < 2).
  - Never assert on a cycle where Fifo_empty_in is high; a read is "accepted" exactly when Fifo_rd_en_out is 1.
- pend <= Fifo_rd_en_out each cycle.
- When pend = 1, Fifo_data_in is written into the skid at the tail at the clock edge.
- Simultaneous push and pop in the same cycle: occ stays unchanged and the FIFO ordering is kept.
- Valid_out = (occ != 0). Data_out = skid head; stable while Valid_out & ~Ready_in.
- Overflow is impossible by construction. A push into occ = 2 without a pop is a design error; the bench asserts that it never happens.
- Latency: read issued in cycle t, data in skid at edge t+1, Valid_out high in cycle t+2.
  - Steady state with Ready_in held high and the FIFO never empty: one word per cycle, no bubbles.
- Frame counter:
  - Increments on each pop.
  - Wraps to 0 after the pop with count = FRAME_LEN-1.
  - Word_idx_out = counter.
  - Last_out = Valid_out & (counter == FRAME_LEN-1).
  - FRAME_LEN = 1 gives Last_out = Valid_out.
- Backpressure: with Ready_in low, reads continue until occ + pend = 2, then stop. No data is lost or duplicated.
- Reset mid-operation: any in-flight word (pend = 1) is discarded. The first pop after reset is index 0.

Optional Feature:
Macro FIFO_STREAM_READER_STATS_EN.
- Defined: adds two 16-bit saturating counters, cleared by Clear_in.
  - Underrun_cnt_out: counts cycles with Ready_in & ~Valid_out.
  - Stall_cnt_out: counts cycles with Valid_out & ~Ready_in.
  - Both counters hold at 16'hFFFF once reached.
  - Also adds the ports Underrun_cnt_out and Stall_cnt_out (out, 16).
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then FIFO preloaded with 0x01..0x05 and Ready_in = 1: Fifo_rd_en_out rises in the first cycle after reset; Valid_out rises 2 cycles later; 0x01..0x05 come out on consecutive cycles; Fifo_rd_en_out stops once Fifo_empty_in is high.
- FIFO holds 10 words, Ready_in = 0: exactly 2 reads issued, then Fifo_rd_en_out = 0; Data_out = first word, held stable. Release Ready_in: all 10 words appear in order, no duplicates.
- Ready_in toggled 1/0 every cycle, 32 words: output sequence matches input exactly; occ never exceeds 2.
- FRAME_LEN = 4, 9 words popped: Last_out on words 3 and 7; Word_idx_out sequence 0,1,2,3,0,1,2,3,0.
- Clear_in asserted one cycle after a read is issued (pend = 1): the next cycle shows Valid_out = 0 and the in-flight word is dropped. After release, a new word 0xAA pops with Word_idx_out = 0.
- With FIFO_STREAM_READER_STATS_EN: 5 cycles with Ready_in = 1 while empty, then 3 cycles with Ready_in = 0 and valid data: Underrun_cnt_out = 5, Stall_cnt_out = 3; saturation checked at 16'hFFFF.
